ir_carrier_generator: RTL

Parametrised, double-buffered carrier/PWM generator for the IR transmit path. It produces a carrier with programmable period and high time, in either continuous mode or a burst of exactly N carrier periods. Period and high time sit in shadow registers and take effect only at a period boundary, so the carrier never glitches. It sits between the code-table sequencer, which programs timing and starts bursts, and the IR LED driver pin.

---
 rtl/ir_carrier_pkg.sv | 14 +
 rtl/carrier_shadow_reg.sv | 47 ++++
 rtl/ir_carrier_generator.sv | 108 ++++++++++
 3 files changed

// File: rtl/ir_carrier_pkg.sv
// Shared types for the IR carrier generator: controller state and run mode encodings.
package ir_carrier_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    MODE_CONT  = 1'b0,
    MODE_BURST = 1'b1
  } mode_t;

endpackage

// File: rtl/carrier_shadow_reg.sv
// Double-buffered period/high-time registers: load fills the pending copy and
// apply promotes a valid pending copy to the active pair on the same edge.
module carrier_shadow_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clock_in,
  input  logic             reset_n_in,
  input  logic             load,
  input  logic             apply,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] high_in,
  output logic [WIDTH-1:0] period_active,
  output logic [WIDTH-1:0] high_active,
  output logic [WIDTH-1:0] high_upcoming
);

  logic [WIDTH-1:0] period_p;
  logic [WIDTH-1:0] high_p;
  logic             pend_v;

  // A load on the same edge as an apply lands in pending and waits for the next apply.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      period_active <= '0;
      high_active   <= '0;
      period_p      <= '0;
      high_p        <= '0;
      pend_v        <= 1'b0;
    end else begin
      if (apply && pend_v) begin
        period_active <= period_p;
        high_active   <= high_p;
      end
      if (load) begin
        period_p <= period_in;
        high_p   <= high_in;
        pend_v   <= 1'b1;
      end else if (apply) begin
        pend_v <= 1'b0;
      end
    end
  end

  // High time that will be active after this edge, so the registered output can look ahead.
  assign high_upcoming = (apply && pend_v) ? high_p : high_active;

endmodule

// File: rtl/ir_carrier_generator.sv
// Carrier/PWM generator for the IR transmit path: continuous or N-period burst,
// with glitch-free timing updates taken only at period boundaries.
module ir_carrier_generator
  import ir_carrier_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic                   enable_in,
  input  logic [WIDTH-1:0]       period_in,
  input  logic [WIDTH-1:0]       high_in,
  input  logic                   load_in,
  input  logic                   mode_in,
  input  logic [BURST_WIDTH-1:0] burst_count_in,
  input  logic                   start_in,
  output logic                   pwm_out,
  output logic                   busy_out,
  output logic                   done_out
);

  state_t                 state_r, state_n;
  mode_t                  mode_r, mode_n;
  logic [WIDTH-1:0]       cnt_r, cnt_n;
  logic [BURST_WIDTH-1:0] rem_r, rem_n;
  logic [WIDTH-1:0]       period_r, high_r, high_upcoming;
  logic                   apply, wrap, pwm_n, done_n;

  carrier_shadow_reg #(.WIDTH(WIDTH)) u_shadow (
    .clock_in      (clock_in),
    .reset_n_in    (reset_n_in),
    .load          (load_in),
    .apply         (apply),
    .period_in     (period_in),
    .high_in       (high_in),
    .period_active (period_r),
    .high_active   (high_r),
    .high_upcoming (high_upcoming)
  );

  assign wrap = (cnt_r == period_r);

  // Next-state logic; pwm is computed from next count and next high time so it is registered.
  always_comb begin
    state_n = state_r;
    mode_n  = mode_r;
    cnt_n   = cnt_r;
    rem_n   = rem_r;
    done_n  = 1'b0;
    apply   = 1'b0;
    unique case (state_r)
      IDLE: begin
        apply = 1'b1;
        cnt_n = '0;
        if (enable_in && start_in) begin
          mode_n = mode_t'(mode_in);
          rem_n  = burst_count_in;
          if (mode_t'(mode_in) == MODE_BURST && burst_count_in == '0)
            done_n = 1'b1;
          else
            state_n = RUN;
        end
      end
      RUN: begin
        if (!enable_in) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (wrap) begin
          apply = 1'b1;
          cnt_n = '0;
          if (mode_r == MODE_BURST) begin
            rem_n = rem_r - BURST_WIDTH'(1);
            if (rem_r == BURST_WIDTH'(1)) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end else begin
          cnt_n = cnt_r + WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    pwm_n = (state_n == RUN) && (cnt_n < (apply ? high_upcoming : high_r));
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_r  <= IDLE;
      mode_r   <= MODE_CONT;
      cnt_r    <= '0;
      rem_r    <= '0;
      pwm_out  <= 1'b0;
      done_out <= 1'b0;
    end else begin
      state_r  <= state_n;
      mode_r   <= mode_n;
      cnt_r    <= cnt_n;
      rem_r    <= rem_n;
      pwm_out  <= pwm_n;
      done_out <= done_n;
    end
  end

  assign busy_out = (state_r == RUN);

endmodule
